// File: rtl/fp_sub_stage_if.sv
// Operand/result bundle for the FP32 subtract stage: operands with a tag in,
// result with the same tag out four edges later.
interface fp_sub_stage_if #(
  parameter int TAG_W = 16
);
  logic             in_valid;
  logic [31:0]      A;
  logic [31:0]      B;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic [31:0]      Y;
  logic [TAG_W-1:0] tag_out;

  modport master (output in_valid, A, B, tag_in, input out_valid, Y, tag_out);
  modport slave  (input in_valid, A, B, tag_in, output out_valid, Y, tag_out);
endinterface

// File: rtl/fp_sub_stage.sv
// Pipelined FP32 subtractor Y = A - B: flush-to-zero in and out, round to nearest even,
// canonical NaN; an op sampled at edge k leaves with out_valid after edge k+4.
module fp_sub_stage #(
  parameter int TAG_W = 16,
  parameter int LAT   = 4
) (
  input logic           clk,
  input logic           rst,
  fp_sub_stage_if.slave bus
);

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [LAT-1:0]    valid_q;
  logic              out_valid_q;
  logic [31:0]       y_q, y_d;
  logic [TAG_W-1:0]  tag_out_q;

  special_e          spec1_d, spec1_q, spec2_q, spec3_q, spec4_q;
  logic              ssign1_d, ssign1_q, ssign2_q, ssign3_q, ssign4_q;
  logic              sx1_d, sx1_q, sx2_q, sx3_q, sx4_q;
  logic              sub1_d, sub1_q, sub2_q;
  logic [7:0]        ex1_d, ex1_q, ex2_q, ex3_q;
  logic [7:0]        d1_d, d1_q;
  logic [23:0]       mx1_d, mx1_q, mx2_q;
  logic [23:0]       mw1_d, mw1_q;
  logic [TAG_W-1:0]  tag1_q, tag2_q, tag3_q, tag4_q;
  logic [26:0]       w_al2_d, w_al2_q;
  logic [27:0]       sum3_d, sum3_q;
  logic [4:0]        lzc3_d, lzc3_q;
  logic signed [9:0] exp4_d, exp4_q;
  logic [26:0]       norm4_d, norm4_q;
  logic              zero4_d, zero4_q;

  // S1: unpack, flush denormals, classify, order operands by magnitude
  logic        sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_ge_b;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  always_comb begin
    // NOTE: every variable here is assigned on every path; a missed branch would infer a latch.
    sa     = bus.A[31];
    sb     = ~bus.B[31];
    ea     = bus.A[30:23];
    eb     = bus.B[30:23];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_nan  = (ea == 8'hFF) && (bus.A[22:0] != 23'h0);
    b_nan  = (eb == 8'hFF) && (bus.B[22:0] != 23'h0);
    a_inf  = (ea == 8'hFF) && (bus.A[22:0] == 23'h0);
    b_inf  = (eb == 8'hFF) && (bus.B[22:0] == 23'h0);
    ma     = a_zero ? 24'h0 : {1'b1, bus.A[22:0]};
    mb     = b_zero ? 24'h0 : {1'b1, bus.B[22:0]};
    a_ge_b = {ea, ma[22:0]} >= {eb, mb[22:0]};

    sx1_d  = a_ge_b ? sa : sb;
    ex1_d  = a_ge_b ? ea : eb;
    mx1_d  = a_ge_b ? ma : mb;
    mw1_d  = a_ge_b ? mb : ma;
    d1_d   = a_ge_b ? ea - eb : eb - ea;
    sub1_d = sa ^ sb;

    spec1_d  = SP_NONE;
    ssign1_d = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      spec1_d = SP_NAN;
    end else if (a_inf) begin
      spec1_d  = SP_INF;
      ssign1_d = sa;
    end else if (b_inf) begin
      spec1_d  = SP_INF;
      ssign1_d = sb;
    end else if (a_zero && b_zero) begin
      spec1_d  = SP_ZERO;
      ssign1_d = sa & sb;
    end
  end

  // S2: align the smaller mantissa into mantissa/guard/round/sticky
  logic [26:0] w_full, w_shift;
  logic        w_lost;

  always_comb begin
    w_full  = {mw1_q, 3'b000};
    w_shift = w_full >> d1_q;
    w_lost  = |(w_full & ~({27{1'b1}} << d1_q));
    if (d1_q >= 8'd27) w_al2_d = {26'h0, |mw1_q};
    else               w_al2_d = {w_shift[26:1], w_shift[0] | w_lost};
  end

  // S3: magnitude add/subtract and leading-zero count below the carry bit
  logic [27:0] x_ext, w_ext;

  always_comb begin
    x_ext  = {1'b0, mx2_q, 3'b000};
    w_ext  = {1'b0, w_al2_q};
    sum3_d = sub2_q ? x_ext - w_ext : x_ext + w_ext;
    lzc3_d = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum3_d[i]) lzc3_d = 5'(26 - i);
    end
  end

  // S4: normalize so the hidden bit sits at bit 26
  always_comb begin
    zero4_d = (sum3_q == 28'h0);
    if (sum3_q[27]) begin
      norm4_d = {sum3_q[27:2], sum3_q[1] | sum3_q[0]};
      exp4_d  = $signed({2'b00, ex3_q}) + 10'sd1;
    end else begin
      norm4_d = sum3_q[26:0] << lzc3_q;
      exp4_d  = $signed({2'b00, ex3_q}) - $signed({5'b00000, lzc3_q});
    end
  end

  // Round to nearest even, pack, then let the S1 special cases override
  logic              round_up;
  logic [24:0]       mant_r;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;

  always_comb begin
    round_up = norm4_q[2] & (norm4_q[1] | norm4_q[0] | norm4_q[3]);
    mant_r   = {1'b0, norm4_q[26:3]} + {24'h0, round_up};
    exp_r    = exp4_q + (mant_r[24] ? 10'sd1 : 10'sd0);
    frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    y_d      = {sx4_q, exp_r[7:0], frac_r};
    case (spec4_q)
      SP_NAN:  y_d = QNAN;
      SP_INF:  y_d = {ssign4_q, 8'hFF, 23'h0};
      SP_ZERO: y_d = {ssign4_q, 31'h0};
      default: begin
        if (zero4_q)                 y_d = 32'h0;
        else if (exp_r >= 10'sd255)  y_d = {sx4_q, 8'hFF, 23'h0};
        else if (exp_r <= 10'sd0)    y_d = {sx4_q, 31'h0};
      end
    endcase
  end

  // NOTE: pipeline data registers have no reset; only valid bits and visible outputs must be defined.
  always_ff @(posedge clk) begin
    spec1_q  <= spec1_d;   ssign1_q <= ssign1_d;  sx1_q  <= sx1_d;   sub1_q <= sub1_d;
    ex1_q    <= ex1_d;     d1_q     <= d1_d;      mx1_q  <= mx1_d;   mw1_q  <= mw1_d;
    tag1_q   <= bus.tag_in;

    spec2_q  <= spec1_q;   ssign2_q <= ssign1_q;  sx2_q  <= sx1_q;   sub2_q <= sub1_q;
    ex2_q    <= ex1_q;     mx2_q    <= mx1_q;     w_al2_q <= w_al2_d;
    tag2_q   <= tag1_q;

    spec3_q  <= spec2_q;   ssign3_q <= ssign2_q;  sx3_q  <= sx2_q;
    ex3_q    <= ex2_q;     sum3_q   <= sum3_d;    lzc3_q <= lzc3_d;
    tag3_q   <= tag2_q;

    spec4_q  <= spec3_q;   ssign4_q <= ssign3_q;  sx4_q  <= sx3_q;
    exp4_q   <= exp4_d;    norm4_q  <= norm4_d;   zero4_q <= zero4_d;
    tag4_q   <= tag3_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so each register samples its source's pre-edge value.
    if (!rst) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      y_q         <= 32'h0;
      tag_out_q   <= '0;
    end else begin
      valid_q     <= {valid_q[LAT-2:0], bus.in_valid};
      out_valid_q <= valid_q[LAT-1];
      if (valid_q[LAT-1]) begin
        y_q       <= y_d;
        tag_out_q <= tag4_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Y         = y_q;
  assign bus.tag_out   = tag_out_q;

endmodule

// File: tb/tb_fp_sub_stage.sv
// Scoreboard bench for fp_sub_stage: directed corner cases plus random streams checked
// against a double-precision reference with flush-to-zero and canonical-NaN rules.
module tb_fp_sub_stage;
  localparam int TAG_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t sb_q[$];

  fp_sub_stage_if #(.TAG_W(TAG_W)) bus_if ();

  fp_sub_stage #(.TAG_W(TAG_W), .LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  function automatic real to_real(input logic [31:0] f);
    if (f[30:23] == 8'h00) return $bitstoreal({f[31], 63'h0});
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rem;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'h0) return {d[63], 31'h0};
    e   = int'(d[62:52]) - 896;
    m   = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0)   return {d[63], 31'h0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (a[31] == b[31]) ? 32'h7FC0_0000 : {a[31], 8'hFF, 23'h0};
    if (a_inf) return {a[31], 8'hFF, 23'h0};
    if (b_inf) return {~b[31], 8'hFF, 23'h0};
    return to_fp32(to_real(a) - to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp(input int base_e);
    int          sel, e;
    logic [22:0] m;
    sel = $urandom_range(0, 19);
    m   = 23'($urandom);
    if (sel == 0) e = 0;
    else if (sel == 1) begin
      e = 255;
      if ($urandom_range(0, 1) == 0) m = '0;
    end else if (sel < 12) begin
      e = base_e + int'($urandom_range(0, 6)) - 3;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end else e = $urandom_range(1, 254);
    return {1'($urandom), 8'(e), m};
  endfunction

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
    int base_e, sel;
    base_e = $urandom_range(1, 254);
    a      = rand_fp(base_e);
    sel    = $urandom_range(0, 9);
    if (sel == 0)      b = a;
    else if (sel == 1) b = a ^ 32'h1;
    else if (sel == 2) b = a ^ 32'h8000_0000;
    else               b = rand_fp(base_e);
  endtask

  task automatic issue_exp(input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input logic [31:0] y);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.A        = a;
    bus_if.B        = b;
    bus_if.tag_in   = tag;
    sb_q.push_back('{y: y, tag: tag, due: cyc + 5});
  endtask

  task automatic issue_rand(input logic [TAG_W-1:0] tag);
    logic [31:0] a, b;
    gen_pair(a, b);
    issue_exp(a, b, tag, ref_sub(a, b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.A        = $urandom;
      bus_if.B        = $urandom;
      bus_if.tag_in   = TAG_W'($urandom);
    end
  endtask

  // Monitor: pops the scoreboard whenever out_valid is seen, flags strays and overdue results
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (bus_if.out_valid !== 1'b0) begin
          if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 32'(bus_if.out_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("y_tag%0h", e.tag), bus_if.Y, e.y);
            check($sformatf("tag_out_tag%0h", e.tag), 32'(bus_if.tag_out), 32'(e.tag));
            check($sformatf("latency_tag%0h", e.tag), 32'(cyc), 32'(e.due));
          end
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
          e = sb_q.pop_front();
          check($sformatf("missing_out_valid_tag%0h", e.tag), 32'd0, 32'd1);
        end
      end
    end
  end

  initial begin
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.A        = '0;
    bus_if.B        = '0;
    bus_if.tag_in   = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("reset_y", bus_if.Y, 32'h0);
    check("reset_tag_out", 32'(bus_if.tag_out), 32'd0);
    rst = 1'b1;

    issue_exp(32'h4248_0000, 32'h4000_0000, 16'h00A5, 32'h4240_0000);
    idle(6);

    issue_exp(32'h4040_0000, 32'h4040_0000, 16'h0001, 32'h0000_0000);
    issue_exp(32'h3F80_0000, 32'h3380_0000, 16'h0002, 32'h3F7F_FFFF);
    issue_exp(32'h3F80_0000, 32'hB380_0000, 16'h0003, 32'h3F80_0000);
    issue_exp(32'h7F80_0000, 32'h7F80_0000, 16'h0004, 32'h7FC0_0000);
    issue_exp(32'h7F7F_FFFF, 32'hFF7F_FFFF, 16'h0005, 32'h7F80_0000);
    issue_exp(32'h7FC0_0001, 32'h3F80_0000, 16'h0006, 32'h7FC0_0000);
    issue_exp(32'h0000_0001, 32'h0000_0000, 16'h0007, 32'h0000_0000);
    issue_exp(32'h8000_0000, 32'h0000_0000, 16'h0008, 32'h8000_0000);
    issue_exp(32'h0000_0000, 32'h8000_0000, 16'h0009, 32'h0000_0000);
    issue_exp(32'h8000_0000, 32'h8000_0000, 16'h000A, 32'h0000_0000);
    issue_exp(32'hFF80_0000, 32'h7F80_0000, 16'h000B, 32'hFF80_0000);
    issue_exp(32'h3F80_0000, 32'h7F80_0000, 16'h000C, 32'hFF80_0000);
    idle(6);

    for (int i = 0; i < 8; i++) issue_rand(TAG_W'(i));
    idle(2);
    for (int i = 8; i < 11; i++) issue_rand(TAG_W'(i));
    idle(6);

    // Reset lands on the same edge that samples the third op
    issue_rand(16'h0100);
    issue_rand(16'h0101);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.A        = 32'h3F80_0000;
    bus_if.B        = 32'h4000_0000;
    bus_if.tag_in   = 16'h0102;
    rst             = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst             = 1'b1;
    bus_if.in_valid = 1'b0;
    check("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("midrst_y", bus_if.Y, 32'h0);
    check("midrst_tag_out", 32'(bus_if.tag_out), 32'd0);
    idle(7);
    check("midrst_y_hold", bus_if.Y, 32'h0);
    issue_exp(32'h4248_0000, 32'h4000_0000, 16'h0200, 32'h4240_0000);
    idle(6);

    for (int i = 0; i < 300; i++) begin
      issue_rand(TAG_W'(16'h1000 + i));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(8);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
